// File: rtl/fpu_issue.sv
// rtl/fpu_issue.sv - in-order FPU command queue with register file, scoreboard and dispatch
module fpu_issue #(
    parameter int          WIDTH  = 32,
    parameter int          NREG   = 32,
    parameter int          DEPTH  = 4,
    parameter logic [5:0]  OP_SET = 6'h01,
    parameter logic [5:0]  OP_FMV = 6'h02,
    localparam int         AW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [5:0]       cmd_op,
    input  logic [AW-1:0]    cmd_x1,
    input  logic [AW-1:0]    cmd_x2,
    input  logic [AW-1:0]    cmd_y,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [5:0]       ex_op,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [AW-1:0]    ex_y,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_y,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [NREG-1:0]  busy,
    output logic             idle,
    output logic             wb_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [5:0]       q_op   [DEPTH];
    logic [AW-1:0]    q_x1   [DEPTH];
    logic [AW-1:0]    q_x2   [DEPTH];
    logic [AW-1:0]    q_y    [DEPTH];
    logic [WIDTH-1:0] q_data [DEPTH];
    logic [WIDTH-1:0] regs   [NREG];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic [5:0]       h_op;
    logic [AW-1:0]    h_x1;
    logic [AW-1:0]    h_x2;
    logic [AW-1:0]    h_y;
    logic [WIDTH-1:0] h_data;
    logic             is_set;
    logic             is_fmv;
    logic             is_disp;
    logic             stall;
    logic             push;
    logic             issue;
    logic             dispatch;
    logic [NREG-1:0]  busy_next;

    assign cmd_ready = count < CW'(DEPTH);
    assign push      = cmd_valid && cmd_ready;

    assign h_op   = q_op[head];
    assign h_x1   = q_x1[head];
    assign h_x2   = q_x2[head];
    assign h_y    = q_y[head];
    assign h_data = q_data[head];

    assign is_set  = (h_op == OP_SET);
    assign is_fmv  = (h_op == OP_FMV);
    assign is_disp = !is_set && !is_fmv;

    // Hazards use the registered scoreboard only; a writeback frees its register for the following cycle.
    always_comb begin
        stall = busy[h_y];
        if (is_fmv)
            stall = stall || busy[h_x1];
        if (is_disp)
            stall = stall || busy[h_x1] || busy[h_x2] || (ex_valid && !ex_ready);
    end

    assign issue    = (count != '0) && !stall;
    assign dispatch = issue && is_disp;

    always_comb begin
        busy_next = busy;
        if (wb_valid)
            busy_next[wb_y] = 1'b0;
        if (dispatch)
            busy_next[h_y] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_op[tail]   <= cmd_op;
            q_x1[tail]   <= cmd_x1;
            q_x2[tail]   <= cmd_x2;
            q_y[tail]    <= cmd_y;
            q_data[tail] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            busy     <= '0;
            wb_err   <= 1'b0;
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_y     <= '0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (issue)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(issue);
            busy  <= busy_next;

            // The busy[y] guard keeps a local write and a writeback off the same register.
            if (wb_valid) begin
                regs[wb_y] <= wb_data;
                if (!busy[wb_y])
                    wb_err <= 1'b1;
            end
            if (issue && is_set)
                regs[h_y] <= h_data;
            else if (issue && is_fmv)
                regs[h_y] <= regs[h_x1];

            if (dispatch) begin
                ex_valid <= 1'b1;
                ex_op    <= h_op;
                ex_a     <= regs[h_x1];
                ex_b     <= regs[h_x2];
                ex_y     <= h_y;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

    assign rd_data = regs[rd_addr];
    assign idle    = (count == '0) && !ex_valid && (busy == '0);
endmodule

// File: tb/tb_fpu_issue.sv
// tb/tb_fpu_issue.sv - directed self-checking bench for fpu_issue
`timescale 1ns/1ps
module tb_fpu_issue;
    localparam logic [5:0] OP_SET  = 6'h01;
    localparam logic [5:0] OP_FMV  = 6'h02;
    localparam logic [5:0] OP_FMUL = 6'h07;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_op = '0;
    logic [4:0]  cmd_x1 = '0, cmd_x2 = '0, cmd_y = '0;
    logic [31:0] cmd_data = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [5:0]  ex_op;
    logic [31:0] ex_a, ex_b;
    logic [4:0]  ex_y;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_y = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [31:0] busy;
    logic        idle;
    logic        wb_err;

    int checks = 0;
    int failures = 0;

    fpu_issue dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .cmd_y(cmd_y), .cmd_data(cmd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_a(ex_a), .ex_b(ex_b), .ex_y(ex_y),
        .wb_valid(wb_valid), .wb_y(wb_y), .wb_data(wb_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .idle(idle), .wb_err(wb_err)
    );

    always #10 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int a, input logic [31:0] exp);
        rd_addr = 5'(a);
        #1;
        chk(tag, {32'h0, rd_data}, {32'h0, exp});
    endtask

    task automatic cmd(input logic [5:0] op, input int x1, input int x2, input int y,
                       input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x1    = 5'(x1);
        cmd_x2    = 5'(x2);
        cmd_y     = 5'(y);
        cmd_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wb_err", 64'(wb_err), 64'd0);

        // SET r0, SET r1: r1 visible two cycles after its acceptance, no ex traffic
        cmd(OP_SET, 0, 0, 0, 32'h0000_0000);
        tick;
        cmd(OP_SET, 0, 0, 1, 32'h3f80_0000);
        tick;
        cmd_valid = 1'b0;
        chk_reg("set_r1_early", 1, 32'h0);
        tick;
        chk_reg("set_r1", 1, 32'h3f80_0000);
        chk("set_ex_valid", 64'(ex_valid), 64'd0);
        chk("set_idle", 64'(idle), 64'd1);

        // SET r0 then FMV r2<-r0 with no stall
        cmd(OP_SET, 0, 0, 0, 32'hbfc0_0000);
        tick;
        cmd(OP_FMV, 0, 0, 2, 32'h0);
        tick;
        cmd_valid = 1'b0;
        chk_reg("fmv_r0", 0, 32'hbfc0_0000);
        chk_reg("fmv_r2_early", 2, 32'h0);
        tick;
        chk_reg("fmv_r2", 2, 32'hbfc0_0000);
        chk("fmv_ex_valid", 64'(ex_valid), 64'd0);

        // FMUL with ex backpressure, dependent FMV stalls on the scoreboard
        cmd(OP_SET, 0, 0, 0, 32'h3e62_4dd2);
        tick;
        cmd(OP_SET, 0, 0, 1, 32'h3fe0_89a0);
        tick;
        ex_ready = 1'b0;
        cmd(OP_FMUL, 0, 1, 2, 32'h0);
        tick;
        cmd(OP_FMV, 2, 0, 3, 32'h0);
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mul_ex_valid", 64'(ex_valid), 64'd1);
            chk("mul_ex_a", 64'(ex_a), 64'h3e62_4dd2);
            chk("mul_ex_b", 64'(ex_b), 64'h3fe0_89a0);
            chk("mul_ex_op", 64'(ex_op), 64'(OP_FMUL));
            chk("mul_ex_y", 64'(ex_y), 64'd2);
            chk("mul_busy", 64'(busy), 64'h4);
            chk("mul_idle", 64'(idle), 64'd0);
            tick;
        end
        ex_ready = 1'b1;
        tick;
        chk("mul_accepted", 64'(ex_valid), 64'd0);
        tick;
        chk_reg("mul_r3_stalled", 3, 32'h0);
        wb_valid = 1'b1;
        wb_y     = 5'd2;
        wb_data  = 32'h3ec2_6a1e;
        tick;
        wb_valid = 1'b0;
        chk_reg("wb_r2", 2, 32'h3ec2_6a1e);
        chk_reg("wb_r3_not_yet", 3, 32'h0);
        chk("wb_busy_clear", 64'(busy), 64'd0);
        tick;
        chk_reg("fmv_after_wb", 3, 32'h3ec2_6a1e);
        chk("wb_err_clean", 64'(wb_err), 64'd0);

        // Full FIFO behind a stalled head, then in-order drain
        cmd(OP_FMUL, 0, 1, 4, 32'h0);
        tick;
        cmd(OP_FMV, 4, 0, 5, 32'h0);
        tick;
        cmd(OP_SET, 0, 0, 6, 32'd1);
        tick;
        chk("fifo_busy4", 64'(busy), 64'h10);
        cmd(OP_SET, 0, 0, 7, 32'd2);
        tick;
        chk("fifo_ready_3", 64'(cmd_ready), 64'd1);
        cmd(OP_SET, 0, 0, 8, 32'd3);
        tick;
        chk("fifo_full", 64'(cmd_ready), 64'd0);
        cmd(OP_SET, 0, 0, 9, 32'd4);
        tick;
        chk("fifo_still_full", 64'(cmd_ready), 64'd0);
        chk_reg("fifo_r6_blocked", 6, 32'h0);
        wb_valid = 1'b1;
        wb_y     = 5'd4;
        wb_data  = 32'h4040_0000;
        tick;
        wb_valid = 1'b0;
        chk("fifo_full_after_wb", 64'(cmd_ready), 64'd0);
        tick;
        chk_reg("fifo_r5", 5, 32'h4040_0000);
        chk("fifo_ready_again", 64'(cmd_ready), 64'd1);
        tick;
        cmd_valid = 1'b0;
        chk_reg("drain_r6", 6, 32'd1);
        chk_reg("drain_r7_pending", 7, 32'd0);
        tick;
        chk_reg("drain_r7", 7, 32'd2);
        chk_reg("drain_r8_pending", 8, 32'd0);
        tick;
        chk_reg("drain_r8", 8, 32'd3);
        chk_reg("drain_r9_pending", 9, 32'd0);
        tick;
        chk_reg("drain_r9", 9, 32'd4);
        chk("drain_idle", 64'(idle), 64'd1);
        chk("drain_wb_err", 64'(wb_err), 64'd0);

        // Writeback to a non-busy register
        wb_valid = 1'b1;
        wb_y     = 5'd5;
        wb_data  = 32'h1234_5678;
        tick;
        wb_valid = 1'b0;
        chk_reg("err_r5", 5, 32'h1234_5678);
        chk("err_set", 64'(wb_err), 64'd1);
        tick;
        tick;
        chk("err_sticky", 64'(wb_err), 64'd1);

        // Reset with queued commands and a pending dispatch
        ex_ready = 1'b0;
        cmd(OP_FMUL, 0, 1, 10, 32'h0);
        tick;
        cmd(OP_FMV, 10, 0, 11, 32'h0);
        tick;
        cmd(OP_SET, 0, 0, 12, 32'h55);
        tick;
        cmd(OP_SET, 0, 0, 13, 32'h66);
        tick;
        cmd_valid = 1'b0;
        chk("pre_rst_ex_valid", 64'(ex_valid), 64'd1);
        chk("pre_rst_idle", 64'(idle), 64'd0);
        chk("pre_rst_busy", 64'(busy), 64'h400);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("post_rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("post_rst_idle", 64'(idle), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_wb_err", 64'(wb_err), 64'd0);
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_ex_a", 64'(ex_a), 64'd0);
        for (int i = 0; i < 32; i++)
            chk_reg("post_rst_reg", i, 32'h0);
        ex_ready = 1'b1;
        tick;
        tick;
        chk_reg("post_rst_r12", 12, 32'h0);
        chk("post_rst_still_idle", 64'(idle), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
